// File: rtl/pipe_stage_buf.sv
// Reusable pipeline stage register with valid/ready handshake, flush and an
// optional skid entry. The control field is zeroed whenever an entry becomes
// a bubble; the data field just holds its last value while invalid.
module pipe_stage_buf #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 120,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        occupancy_o
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic              accept, emit;

  // With the skid entry, in_ready is a pure decode of the state register so
  // out_ready never reaches in_ready combinationally. Without it, a held
  // head may be replaced in the cycle it drains. FULL is unreachable when
  // SKID=0 because an Accept in ONE then always coincides with an Emit.
  assign in_ready_o  = SKID ? (state_q != FULL)
                            : ((state_q == EMPTY) | out_ready_i);
  assign out_valid_o = (state_q != EMPTY);
  assign out_ctrl_o  = m_ctrl_q;
  assign out_data_o  = m_data_q;
  assign occupancy_o = state_q;

  assign accept = in_valid_i & in_ready_o;
  assign emit   = out_valid_o & out_ready_i;

  // Next-state and payload movement; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush_i) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_ctrl_d = in_ctrl_i;
            m_data_d = in_data_i;
            state_d  = ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            m_ctrl_d = in_ctrl_i;
            m_data_d = in_data_i;
          end else if (accept) begin
            s_ctrl_d = in_ctrl_i;
            s_data_d = in_data_i;
            state_d  = FULL;
          end else if (emit) begin
            m_ctrl_d = '0;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            s_ctrl_d = '0;
            state_d  = ONE;
          end
        end
        default: begin
          state_d  = EMPTY;
          m_ctrl_d = '0;
          s_ctrl_d = '0;
        end
      endcase
    end
  end

  // State and payload registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      if (SKID) begin
        s_ctrl_q <= s_ctrl_d;
        s_data_q <= s_data_d;
      end
    end
  end

endmodule
